dm_arbiter: RTL and testbench

- Shares the single-port word data memory (DM, 3072 x 32, word index = addr[13:2]) between two requesters: the CPU MEM stage (port C) and a debug/loader port (port D).
- Fixed priority to the CPU, with a starvation counter that forces one debug access after STARVE_MAX consecutive denials.
- Drives the DM address, write-data, write-select and trace-PC inputs.
- Returns combinational read data to the CPU and registered read data to the debug port.

---
 rtl/dm_arbiter_pkg.sv | 26 ++
 rtl/dm_arbiter.sv | 148 ++++++++++++++
 tb/tb_dm_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg
// Purpose : constants and types shared by the data-memory arbiter.
//   DM_WORDS    number of valid words in the data memory
//   DM_IDX_*    bit slice of a byte address that selects a DM word
//   DBG_PC      trace PC reported to the DM for debug-port writes
//   pri_e       arbiter priority state encoding
package dm_arbiter_pkg;

  localparam int unsigned DM_WORDS   = 3072;
  localparam int unsigned DM_IDX_MSB = 13;
  localparam int unsigned DM_IDX_LSB = 2;
  localparam logic [31:0] DBG_PC     = 32'hFFFF_FFFC;

  typedef enum logic {
    PRI_C = 1'b0,
    PRI_D = 1'b1
  } pri_e;

  // The full word index (addr[31:2]) is compared, so addresses that would
  // alias onto the DM through the [13:2] slice are still rejected.
  function automatic logic word_in_range(input logic [29:0] word_idx,
                                         input int unsigned words);
    return {2'b00, word_idx} < words;
  endfunction

endpackage

// File: rtl/dm_arbiter.sv
// dm_arbiter
// Purpose : shares the single-port data memory between the CPU MEM stage
//           (port C, fixed priority) and a debug/loader port (port D).
//           A starvation counter forces one debug grant after STARVE_MAX
//           consecutive debug denials.
// Ports   :
//   clk, reset                 clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata/c_pc   CPU access request
//   c_gnt/c_stall/c_rdata            CPU grant, stall, combinational read data
//   d_req/d_we/d_addr/d_wdata        debug access request (held until d_gnt)
//   d_gnt/d_rdata/d_rvalid/d_err     debug grant, registered read data/flags
//   mem_addr/mem_wdata/mem_sel/mem_pc   DM inputs
//   mem_rdata                        DM combinational read data
//
// state | meaning
// PRI_C | CPU wins a conflict (normal operation)
// PRI_D | debug port wins a conflict (starvation limit reached)
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned DM_WORDS   = dm_arbiter_pkg::DM_WORDS,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] DBG_PC     = dm_arbiter_pkg::DBG_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [31:0] c_pc,
  output logic        c_gnt,
  output logic        c_stall,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_sel,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  pri_e        state_q, state_d;
  logic [3:0]  starv_cnt_q, starv_cnt_d;
  logic [3:0]  starv_inc;
  logic        d_rvalid_q, d_rvalid_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        c_in_range, d_in_range;

  assign c_in_range = word_in_range(c_addr[31:2], DM_WORDS);
  assign d_in_range = word_in_range(d_addr[31:2], DM_WORDS);
  assign starv_inc  = starv_cnt_q + 4'd1;

  // Grants are suppressed while reset is asserted so no access lands in the
  // reset cycle; requesters simply re-present afterwards.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (state_q == PRI_C) begin
        c_gnt = c_req;
        d_gnt = d_req & ~c_req;
      end else begin
        d_gnt = d_req;
        c_gnt = c_req & ~d_req;
      end
    end
  end

  assign c_stall = c_req & ~c_gnt;
  assign c_rdata = mem_rdata;

  // Out-of-range accesses are still granted but never write the DM.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sel   = 1'b0;
    mem_pc    = '0;
    if (c_gnt) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_sel   = c_we & c_in_range;
      mem_pc    = c_pc;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_sel   = d_we & d_in_range;
      mem_pc    = DBG_PC;
    end
  end

  always_comb begin
    state_d     = state_q;
    starv_cnt_d = starv_cnt_q;
    if (d_gnt) begin
      starv_cnt_d = '0;
      state_d     = PRI_C;
    end else if (d_req) begin
      starv_cnt_d = starv_inc;
      if (starv_inc == STARVE_LIM) begin
        state_d = PRI_D;
      end
    end else begin
      // A pending PRI_D is kept until the debug port is actually served.
      starv_cnt_d = '0;
    end
  end

  always_comb begin
    d_rvalid_d = d_gnt & ~d_we;
    d_err_d    = d_gnt & ~d_in_range;
    d_rdata_d  = d_rdata_q;
    if (d_gnt && !d_we) begin
      d_rdata_d = d_in_range ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PRI_C;
      starv_cnt_q <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starv_cnt_q <= starv_cnt_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign d_rvalid = d_rvalid_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
// Purpose : directed plus randomized bench for dm_arbiter. A behavioural
//           DM model answers the arbiter; a separate reference model tracks
//           expected memory contents, debug starvation and grants.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, c_pc = '0;
  logic        c_gnt, c_stall;
  logic [31:0] c_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic        mem_sel;

  dm_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_pc(c_pc),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_pc(mem_pc),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port DM: combinational read, write at clock edge.
  logic [31:0] dm [DM_WORDS];
  logic [11:0] dm_idx;
  assign dm_idx    = mem_addr[DM_IDX_MSB:DM_IDX_LSB];
  assign mem_rdata = (int'(dm_idx) < DM_WORDS) ? dm[dm_idx] : {20'hBAD00, dm_idx};
  always @(posedge clk) if (mem_sel && int'(dm_idx) < DM_WORDS) dm[dm_idx] <= mem_wdata;

  // Reference model state
  logic [31:0] ref_mem [DM_WORDS];
  int          m_denials = 0;
  bit          m_dbg_first = 0;
  logic        m_rvalid = 0, m_err = 0;
  logic [31:0] m_rdata = '0;

  int n_vec = 0, n_err = 0;
  logic        obs_cg, obs_dg, obs_rvalid, obs_err;
  logic [31:0] obs_crdata, obs_drdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [11:0] i;
    i = a[DM_IDX_MSB:DM_IDX_LSB];
    return (int'(i) < DM_WORDS) ? ref_mem[i] : {20'hBAD00, i};
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < DM_WORDS;
  endfunction

  // One clock cycle: check at negedge against the model, then advance the
  // model at the posedge and return just after it so callers can drive.
  task automatic cycle();
    logic egc, egd, e_sel, ci, di;
    logic [31:0] e_addr, e_wdata, e_pc;
    @(negedge clk);
    ci = in_rng(c_addr);
    di = in_rng(d_addr);
    if (reset) begin egc = 0; egd = 0; end
    else if (c_req && d_req) begin egd = m_dbg_first; egc = !m_dbg_first; end
    else begin egc = c_req; egd = d_req; end
    e_addr = '0; e_wdata = '0; e_sel = 0; e_pc = '0;
    if (egc) begin e_addr = c_addr; e_wdata = c_wdata; e_sel = c_we && ci; e_pc = c_pc; end
    else if (egd) begin e_addr = d_addr; e_wdata = d_wdata; e_sel = d_we && di; e_pc = 32'hFFFF_FFFC; end
    chk("c_gnt", c_gnt, egc);
    chk("d_gnt", d_gnt, egd);
    chk("c_stall", c_stall, c_req && !egc);
    chk("mem_sel", mem_sel, e_sel);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_pc", mem_pc, e_pc);
    if (egc && !c_we) chk("c_rdata", c_rdata, ref_rd(c_addr));
    chk("d_rvalid", d_rvalid, m_rvalid);
    chk("d_err", d_err, m_err);
    chk("d_rdata", d_rdata, m_rdata);
    obs_cg = c_gnt; obs_dg = d_gnt; obs_crdata = c_rdata;
    obs_rvalid = d_rvalid; obs_err = d_err; obs_drdata = d_rdata;
    @(posedge clk);
    if (reset) begin
      m_denials = 0; m_dbg_first = 0; m_rvalid = 0; m_err = 0; m_rdata = '0;
    end else begin
      m_rvalid = egd && !d_we;
      m_err    = egd && !di;
      if (egd && !d_we) m_rdata = di ? ref_mem[d_addr[DM_IDX_MSB:DM_IDX_LSB]] : '0;
      if (egc && c_we && ci) ref_mem[c_addr[DM_IDX_MSB:DM_IDX_LSB]] = c_wdata;
      if (egd && d_we && di) ref_mem[d_addr[DM_IDX_MSB:DM_IDX_LSB]] = d_wdata;
      if (egd) begin m_denials = 0; m_dbg_first = 0; end
      else if (d_req) begin
        m_denials++;
        if (m_denials >= STARVE) m_dbg_first = 1;
      end else m_denials = 0;
    end
    #1;
  endtask

  // CPU grants seen before the first debug grant (bounded).
  task automatic count_until_dgnt(output int cnt);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (obs_dg) break;
      cnt += int'(obs_cg);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = 32'h0000_3000 + (32'($urandom_range(0, 15)) << 2);
      1: a = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 2);
      2: a = 32'h0000_2FFC;
      default: a = 32'($urandom_range(0, 15)) << 2;
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int cnt;
    for (int i = 0; i < DM_WORDS; i++) begin
      dm[i]      = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
      ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    end
    obs_dg = 0;

    cycle(); cycle();
    chk("rst_rvalid", obs_rvalid, 1'b0);
    reset = 0;

    // CPU write then read back
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'h1234_5678; c_pc = 32'h3000;
    cycle();
    chk("t1_gnt", obs_cg, 1'b1);
    c_we = 0;
    cycle();
    chk("t1_rd", obs_crdata, 32'h1234_5678);

    // Debug write / read with CPU idle
    c_req = 0; d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    cycle();
    chk("t3_dgnt", obs_dg, 1'b1);
    d_we = 0;
    cycle();
    d_req = 0;
    cycle();
    chk("t3_rvalid", obs_rvalid, 1'b1);
    chk("t3_rdata", obs_drdata, 32'hDEAD_BEEF);

    // Out-of-range debug write
    d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hFFFF_0000;
    cycle();
    d_req = 0;
    cycle();
    chk("t4_err", obs_err, 1'b1);
    c_req = 1; c_we = 0; c_addr = 32'h0;
    cycle();
    chk("t4_word0", obs_crdata, 32'h5A5A_0000);

    // Starvation with both requests held
    c_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h10;
    count_until_dgnt(cnt);
    chk("t2_starve", cnt, STARVE);
    cycle();
    chk("t2_cback", obs_cg, 1'b1);
    chk("t2_rvalid", obs_rvalid, 1'b1);

    // Reset clears a partial starvation count
    cycle(); cycle();
    reset = 1;
    cycle();
    reset = 0;
    count_until_dgnt(cnt);
    chk("t5_starve", cnt, STARVE);

    // Dropping d_req restarts the count
    cycle(); cycle();
    d_req = 0;
    cycle();
    d_req = 1;
    count_until_dgnt(cnt);
    chk("t6_starve", cnt, STARVE);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      reset   = ($urandom_range(0, 59) == 0);
      c_req   = ($urandom_range(0, 2) != 0);
      c_we    = 1'($urandom_range(0, 1));
      c_addr  = rand_addr();
      c_wdata = $urandom;
      c_pc    = $urandom & 32'hFFFF_FFFC;
      if (obs_dg || !d_req) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
